// File: rtl/uart_inst_loader.sv
// Loads a length-prefixed stream of 32-bit instruction words from a UART byte stream into instruction memory.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
module uart_inst_loader #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [31:0]   asm_q, asm_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timed, in_busy;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  always_comb begin
    in_busy = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA) || (state_q == WRITE);
    timed   = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
`ifdef LOADER_CHECKSUM_EN
    in_busy = in_busy || (state_q == CHK);
    timed   = timed || (state_q == CHK);
`endif
  end

  // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d   = chk_q;
    if (rx_valid && in_busy) chk_d = chk_q ^ rx_data;
`endif
    // The counter may step one past the limit during WRITE, hence the >= test below.
    if (in_busy) tmo_d = rx_valid ? '0 : tmo_q + TW'(1);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          wcnt_d  = '0;
          tmo_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      LEN_HI: if (rx_valid) begin
        len_d[15:8] = rx_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (rx_valid) begin
        len_d[7:0] = rx_data;
        bcnt_d     = '0;
        state_d    = ({len_q[15:8], rx_data} == 16'd0) ? END_ST : DATA;
      end
      DATA: if (rx_valid) begin
        asm_d  = {asm_q[23:0], rx_data};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        wcnt_d = wcnt_q + 16'd1;
        if (wcnt_q + 16'd1 != len_q) begin
          state_d = DATA;
          if (rx_valid) begin
            asm_d  = {asm_q[23:0], rx_data};
            bcnt_d = 2'd1;
          end
        end else begin
          state_d = END_ST;
`ifdef LOADER_CHECKSUM_EN
          // A byte arriving in the final WRITE cycle is already the checksum.
          if (rx_valid) state_d = (rx_data == chk_q) ? DONE : ERR;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: if (rx_valid) state_d = (rx_data == chk_q) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase

    if (timed && !rx_valid && (tmo_q >= TW'(TIMEOUT_CYC - 1))) state_d = ERR;
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously on rst.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      asm_q   <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      tmo_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = wcnt_q[ADDR_W-1:0];
  assign imem_wdata = asm_q;
  assign cpu_hold   = (state_q != DONE);
  assign busy       = in_busy;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign word_cnt   = wcnt_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Scoreboard bench for uart_inst_loader: expected memory writes are queued as frames are sent.
// Build with LOADER_CHECKSUM_EN defined to exercise the checksum variant.
module tb_uart_inst_loader;

  localparam int AW  = 2;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid;
  logic [7:0]    rx_data;
  logic          imem_we, cpu_hold, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [15:0]   word_cnt;

  uart_inst_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk_100MHz(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wds[$];
  logic [7:0]  xsum;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) check("unexpected_we", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("we_addr", 32'(imem_addr), 32'(e.addr));
        check("we_data", imem_wdata, e.data);
      end
    end
  end

  // All tasks begin and end on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic sendx(input logic [7:0] b, input int gap);
    xsum = xsum ^ b;
    send(b, gap);
  endtask

  // Sends length + words from wds; with the checksum build appends the XOR (or 0x00 when bad).
  task automatic frame(input int gap, input bit bad);
    logic [15:0] nn;
    logic [31:0] w;
    nn   = 16'(wds.size());
    xsum = 8'h00;
    sendx(nn[15:8], gap);
    sendx(nn[7:0], gap);
    for (int i = 0; i < wds.size(); i++) begin
      w = wds[i];
      exp_q.push_back('{addr: AW'(i), data: w});
      for (int k = 3; k >= 0; k--) sendx(w[8*k +: 8], gap);
    end
`ifdef LOADER_CHECKSUM_EN
    send(bad ? 8'h00 : xsum, gap);
`endif
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    while (!done && !error && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done && !error) check("end_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(3);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_wcnt", 32'(word_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b0;
    tick(2);

    // Basic two-word frame
    wds = '{32'hDEADBEEF, 32'h00000013};
    pulse_start();
    check("armed_busy", 32'(busy), 32'd1);
    check("armed_hold", 32'(cpu_hold), 32'd1);
    frame(2, 1'b0);
    wait_end(200);
    check("f1_done", 32'(done), 32'd1);
    check("f1_error", 32'(error), 32'd0);
    check("f1_hold", 32'(cpu_hold), 32'd0);
    check("f1_busy", 32'(busy), 32'd0);
    check("f1_wcnt", 32'(word_cnt), 32'd2);
    check("f1_pending", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) send(8'h55, 0);
    check("done_ignores_rx", 32'(done), 32'd1);
    check("done_wcnt_hold", 32'(word_cnt), 32'd2);

`ifdef LOADER_CHECKSUM_EN
    // Wrong trailing checksum
    pulse_start();
    check("restart_clears_done", 32'(done), 32'd0);
    frame(1, 1'b1);
    wait_end(200);
    check("badsum_error", 32'(error), 32'd1);
    check("badsum_done", 32'(done), 32'd0);
    check("badsum_hold", 32'(cpu_hold), 32'd1);
    check("badsum_pending", 32'(exp_q.size()), 32'd0);
`endif

    // Back-to-back bytes (byte during WRITE), address wrap, ignored mid-frame start
    wds = '{32'h01020304, 32'hA5A5_5A5A, 32'hCAFEF00D, 32'h12345678, 32'h87654321};
    pulse_start();
    fork
      frame(0, 1'b0);
      begin
        tick(6);
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end
    join
    wait_end(200);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_wcnt", 32'(word_cnt), 32'd5);
    check("b2b_pending", 32'(exp_q.size()), 32'd0);

    // Zero-length frame
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    check("zero_in_chk", 32'(busy), 32'd1);
    send(8'h00, 0);
`endif
    check("zero_done", 32'(done), 32'd1);
    check("zero_wcnt", 32'(word_cnt), 32'd0);

    // Inter-byte timeout mid-word
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hAA, 0);
    tick(TMO / 2);
    check("tmo_early_error", 32'(error), 32'd0);
    check("tmo_early_busy", 32'(busy), 32'd1);
    tick(TMO);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_wcnt", 32'(word_cnt), 32'd0);

    // Reset mid-word, then a clean one-word frame
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    wds = '{32'h11223344};
    pulse_start();
    frame(1, 1'b0);
    wait_end(200);
    check("postrst_done", 32'(done), 32'd1);
    check("postrst_wcnt", 32'(word_cnt), 32'd1);
    check("postrst_pending", 32'(exp_q.size()), 32'd0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
